// File: rtl/qk_score_scheduler.sv
// Serial Q*K^T score sequencer: walks every (row, col) pair through one shared dot-product engine.
// Optional macro QK_SCHED_PERF_EN adds perf_cycles / perf_stall counters.
module qk_score_scheduler #(
  parameter int DATA_WIDTH      = 16,
  parameter int TOKEN_DIM       = 4,
  parameter int TOKEN_NUM       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] Q_in,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] K_in,
  input  logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_in,
  output logic                                      dp_req_valid,
  input  logic                                      dp_req_ready,
  output logic [DATA_WIDTH*TOKEN_DIM-1:0]           dp_a,
  output logic [DATA_WIDTH*TOKEN_DIM-1:0]           dp_b,
  input  logic                                      dp_resp_valid,
  input  logic [DATA_WIDTH-1:0]                     dp_resp,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DATA_WIDTH*TOKEN_NUM*TOKEN_NUM-1:0] A_out,
  output logic [DATA_WIDTH*TOKEN_DIM*TOKEN_NUM-1:0] V_out
`ifdef QK_SCHED_PERF_EN
  ,
  output logic [31:0]                               perf_cycles,
  output logic [31:0]                               perf_stall
`endif
);

  localparam int TOTAL = TOKEN_NUM * TOKEN_NUM;
  localparam int ROW_W = DATA_WIDTH * TOKEN_DIM;
  localparam int MAT_W = ROW_W * TOKEN_NUM;
  localparam int A_W   = DATA_WIDTH * TOTAL;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TOK_W = (TOKEN_NUM > 1) ? $clog2(TOKEN_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] TOK_IDX  = IDX_W'(TOKEN_NUM);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_inReady;
  logic               r_outValid;
  logic [MAT_W-1:0]   r_q;
  logic [MAT_W-1:0]   r_k;
  logic [MAT_W-1:0]   r_v;
  logic [A_W-1:0]     r_a;
  logic [IDX_W-1:0]   r_iss;
  logic [IDX_W-1:0]   r_wr;
  logic [OUT_W-1:0]   r_out;

  logic               w_fire;
  logic               w_respOk;
  logic [IDX_W-1:0]   w_issSafe;
  logic [TOK_W-1:0]   w_row;
  logic [TOK_W-1:0]   w_col;

  // Clamp the index once all pairs are issued so the row/col select never leaves the matrix.
  assign w_issSafe    = (r_iss < LAST_IDX) ? r_iss : '0;
  assign w_row        = TOK_W'(w_issSafe / TOK_IDX);
  assign w_col        = TOK_W'(w_issSafe % TOK_IDX);
  assign dp_a         = r_q[w_row*ROW_W +: ROW_W];
  assign dp_b         = r_k[w_col*ROW_W +: ROW_W];
  assign dp_req_valid = (r_state == S_RUN) && (r_iss < LAST_IDX) && (r_out < OUT_MAX);
  assign w_fire       = dp_req_valid && dp_req_ready;
  assign w_respOk     = (r_state == S_RUN) && dp_resp_valid && (r_out != '0);

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign A_out     = r_a;
  assign V_out     = r_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_q        <= '0;
      r_k        <= '0;
      r_v        <= '0;
      r_a        <= '0;
      r_iss      <= '0;
      r_wr       <= '0;
      r_out      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q       <= Q_in;
            r_k       <= K_in;
            r_v       <= V_in;
            r_iss     <= '0;
            r_wr      <= '0;
            r_out     <= '0;
            r_inReady <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_fire) r_iss <= r_iss + IDX_W'(1);
          if (w_respOk) begin
            r_a[r_wr*DATA_WIDTH +: DATA_WIDTH] <= dp_resp;
            r_wr <= r_wr + IDX_W'(1);
          end
          // A request and a response in the same cycle cancel out.
          case ({w_fire, w_respOk})
            2'b10:   r_out <= r_out + OUT_W'(1);
            2'b01:   r_out <= r_out - OUT_W'(1);
            default: r_out <= r_out;
          endcase
          if (r_wr == LAST_IDX) begin
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef QK_SCHED_PERF_EN
  logic [31:0] r_perfCycles;
  logic [31:0] r_perfStall;

  // Both counters restart on job capture and saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perfCycles <= '0;
      r_perfStall  <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_perfCycles <= '0;
      r_perfStall  <= '0;
    end else if (r_state == S_RUN) begin
      if (r_perfCycles != '1) r_perfCycles <= r_perfCycles + 32'd1;
      if (dp_req_valid && !dp_req_ready && r_perfStall != '1) r_perfStall <= r_perfStall + 32'd1;
    end
  end

  assign perf_cycles = r_perfCycles;
  assign perf_stall  = r_perfStall;
`endif

endmodule

// File: tb/tb_qk_score_scheduler.sv
// Scoreboard bench for qk_score_scheduler with a latency-configurable engine model.
module tb_qk_score_scheduler;

  localparam int DW    = 16;
  localparam int TD    = 2;
  localparam int TN    = 2;
  localparam int MAXO  = 4;
  localparam int TOTAL = TN * TN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [63:0]     Q_in = '0;
  logic [63:0]     K_in = '0;
  logic [63:0]     V_in = '0;
  logic            dp_req_valid;
  logic            dp_req_ready = 1'b1;
  logic [31:0]     dp_a;
  logic [31:0]     dp_b;
  logic            dp_resp_valid = 1'b0;
  logic [15:0]     dp_resp = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [63:0]     A_out;
  logic [63:0]     V_out;
`ifdef QK_SCHED_PERF_EN
  logic [31:0]     perf_cycles;
  logic [31:0]     perf_stall;
`endif

  qk_score_scheduler #(
    .DATA_WIDTH(DW), .TOKEN_DIM(TD), .TOKEN_NUM(TN), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Q_in(Q_in), .K_in(K_in), .V_in(V_in),
    .dp_req_valid(dp_req_valid), .dp_req_ready(dp_req_ready),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_resp_valid(dp_resp_valid), .dp_resp(dp_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .A_out(A_out), .V_out(V_out)
`ifdef QK_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] val;
  } engEntry_t;

  engEntry_t   engQ[$];
  logic [15:0] sbQ[$];

  int compared = 0;
  int mismatched = 0;
  int cycle = 0;
  int engLat = 1;
  int engMode = 0;
  bit inRun = 0;
  int reqCnt = 0;
  int respCnt = 0;
  int benchOut = 0;
  int maxOut = 0;
  bit sawLimit = 0;
  int stallCnt = 0;
  int runCycles = 0;
  bit prevStall = 0;
  logic [31:0] prevA, prevB;
  logic [63:0] curQ, curK, curV;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Stand-in for the FP engine: exact for unit-vector rows, an arbitrary but fixed mix otherwise.
  function automatic logic [15:0] dotModel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h0000_3C00) return b[15:0];
    if (a == 32'h3C00_0000) return b[31:16];
    return (a[15:0] ^ b[15:0]) + (a[31:16] ^ b[31:16]);
  endfunction

  task automatic step();
    logic fire, respNow, expValid;
    logic [31:0] qRow, kRow;
    fire     = dp_req_valid && dp_req_ready;
    respNow  = dp_resp_valid;
    expValid = inRun && (reqCnt < TOTAL) && (benchOut < MAXO);
    if (inRun && !out_valid) begin
      runCycles++;
      checkOutput("reqValid", dp_req_valid, expValid);
      if (dp_req_valid && !dp_req_ready) stallCnt++;
      if (prevStall) begin
        checkOutput("stallA", dp_a, prevA);
        checkOutput("stallB", dp_b, prevB);
      end
      if (benchOut == MAXO) sawLimit = 1;
      if (respNow) begin
        benchOut--;
        respCnt++;
      end
      if (fire) begin
        qRow = curQ[(reqCnt / TN)*32 +: 32];
        kRow = curK[(reqCnt % TN)*32 +: 32];
        checkOutput($sformatf("reqA[%0d]", reqCnt), dp_a, qRow);
        checkOutput($sformatf("reqB[%0d]", reqCnt), dp_b, kRow);
        sbQ.push_back(dotModel(qRow, kRow));
        engQ.push_back('{due: cycle + 1 + engLat, val: dotModel(dp_a, dp_b)});
        reqCnt++;
        benchOut++;
        if (benchOut > maxOut) maxOut = benchOut;
      end
      prevStall = dp_req_valid && !dp_req_ready;
      prevA = dp_a;
      prevB = dp_b;
    end
    @(posedge clk);
    cycle++;
    #1;
    dp_req_ready = (engMode == 0) ? 1'b1 : ~dp_req_ready;
    dp_resp_valid = 1'b0;
    if (engQ.size() > 0 && engQ[0].due <= cycle + 1) begin
      dp_resp_valid = 1'b1;
      dp_resp = engQ[0].val;
      void'(engQ.pop_front());
    end
    #1;
  endtask

  task automatic clearModel();
    engQ.delete();
    sbQ.delete();
    inRun = 0; reqCnt = 0; respCnt = 0; benchOut = 0; maxOut = 0;
    sawLimit = 0; stallCnt = 0; runCycles = 0; prevStall = 0;
  endtask

  task automatic applyStimulus(input logic [63:0] q, input logic [63:0] k, input logic [63:0] v,
                               input int lat, input int mode);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    checkOutput("inReadyBeforeJob", in_ready, 1'b1);
    clearModel();
    engLat = lat; engMode = mode;
    curQ = q; curK = k; curV = v;
    Q_in = q; K_in = k; V_in = v;
    dp_req_ready = (mode == 0) ? 1'b1 : 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    inRun = 1;
  endtask

  task automatic collectResult(input int hold);
    int n = 0;
    logic [63:0] snap;
    while (!out_valid && n < 300) begin step(); n++; end
    checkOutput("doneReached", out_valid, 1'b1);
    inRun = 0;
    checkOutput("maxOutstandingOk", maxOut <= MAXO, 1'b1);
    for (int e = 0; e < TOTAL; e++) begin
      if (sbQ.size() == 0) checkOutput($sformatf("sbEmpty[%0d]", e), 1'b0, 1'b1);
      else checkOutput($sformatf("A[%0d]", e), A_out[e*DW +: DW], sbQ.pop_front());
    end
    checkOutput("vOut", V_out, curV);
    snap = A_out;
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput("holdValid", out_valid, 1'b1);
      checkOutput("holdA", A_out, snap);
      checkOutput("holdInReady", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("outValidDropped", out_valid, 1'b0);
    checkOutput("inReadyBack", in_ready, 1'b1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int stallSeen, runSeen;
    rst = 1'b1;
    repeat (3) step();
    checkOutput("rstInReady", in_ready, 1'b1);
    checkOutput("rstReqValid", dp_req_valid, 1'b0);
    checkOutput("rstOutValid", out_valid, 1'b0);
    checkOutput("rstA", A_out, 64'h0);
    checkOutput("rstV", V_out, 64'h0);
    rst = 1'b0;
    step();

    // Identity Q against K=[[2,3],[4,5]] in fp16.
    applyStimulus(64'h3C00_0000_0000_3C00, 64'h4500_4400_4200_4000, 64'h1111_2222_3333_4444, 1, 0);
    collectResult(0);
    checkOutput("identityA", A_out, 64'h4500_4200_4400_4000);

    // Long engine latency pushes the scheduler up against its outstanding limit.
    applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 6, 0);
    collectResult(0);
    checkOutput("sawOutstandingLimit", sawLimit, 1'b1);

    // Alternating engine ready plus a consumer that stalls in DONE.
    applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 2, 1);
    stallSeen = 0;
    runSeen = 0;
    collectResult(10);
    stallSeen = stallCnt;
    runSeen = runCycles;
    checkOutput("stallsObserved", stallSeen > 0, 1'b1);
`ifdef QK_SCHED_PERF_EN
    checkOutput("perfStall", perf_stall, stallSeen);
    checkOutput("perfCycles", perf_cycles, runSeen);
`endif

    // Reset in the middle of a job, then a stray engine response.
    applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()}, 64'hDEAD_BEEF_0BAD_F00D, 1, 0);
    n = 0;
    while (respCnt < 2 && n < 50) begin step(); n++; end
    checkOutput("twoResponsesSeen", respCnt >= 2, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clearModel();
    checkOutput("midRstOutValid", out_valid, 1'b0);
    checkOutput("midRstInReady", in_ready, 1'b1);
    checkOutput("midRstA", A_out, 64'h0);
    checkOutput("midRstV", V_out, 64'h0);
    dp_resp_valid = 1'b1;
    dp_resp = 16'h1234;
    step();
    checkOutput("lateRespIgnored", A_out, 64'h0);
    checkOutput("lateRespInReady", in_ready, 1'b1);

    // Recovery job after the reset.
    applyStimulus({$urandom(), $urandom()}, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 3, 0);
    collectResult(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/qk_score_scheduler.md
Name: qk_score_scheduler

Overview:
Sequencer that computes A = Q·K^T one score at a time on a single shared FP dot-product engine. It is the low-area alternative to the fully parallel first attention stage.
- Accepts one Q/K/V job through a valid/ready handshake and walks all TOKEN_NUM×TOKEN_NUM (row, col) pairs in row-major order.
- Drives the engine with in-order requests and gathers results into a score buffer.
- Presents A with the pass-through V to the next stage through an output handshake.

Parameters:
- DATA_WIDTH, 16, bits per FP element.
- TOKEN_DIM, 4, elements per token vector.
- TOKEN_NUM, 8, tokens; A is TOKEN_NUM×TOKEN_NUM.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered engine requests (1..16).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  scheduler can accept a job.
- Q_in  in  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  Q matrix.
- K_in  in  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  K matrix, untransposed.
- V_in  in  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  V matrix, passed through.
- dp_req_valid  out  1  engine request valid.
- dp_req_ready  in  1  engine accepts request.
- dp_a  out  DATA_WIDTH*TOKEN_DIM  Q row i.
- dp_b  out  DATA_WIDTH*TOKEN_DIM  K row j.
- dp_resp_valid  in  1  engine result valid, in request order.
- dp_resp  in  DATA_WIDTH  dot-product result.
- out_valid  out  1  A/V ready.
- out_ready  in  1  consumer accepts.
- A_out  out  DATA_WIDTH*TOKEN_NUM*TOKEN_NUM  score matrix.
- V_out  out  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  registered V.

Behaviour:
- Packing: element (r,c) of an R×C matrix sits at bits [(r*C+c)*DATA_WIDTH +: DATA_WIDTH]. Same rule for Q, K, V and A.
- Reset: state=IDLE. in_ready=1, dp_req_valid=0, out_valid=0. A_out, V_out, all counters and internal Q/K registers are 0.
- States:
  - IDLE: in_ready=1. On in_valid, capture Q_in, K_in, V_in. Clear issue index iss=0, write index wr=0, outstanding=0. Go to RUN.
  - RUN: in_ready=0. dp_req_valid=1 while iss<TOKEN_NUM² and outstanding<MAX_OUTSTANDING. dp_a=Q row iss/TOKEN_NUM, dp_b=K row iss%TOKEN_NUM, both combinational from the captured registers and iss.
    - Request fires on dp_req_valid&dp_req_ready: iss+1, outstanding+1.
    - On dp_resp_valid: write dp_resp into A element index wr, then wr+1, outstanding-1.
    - Fire and response in the same cycle leave outstanding unchanged.
    - When wr reaches TOKEN_NUM² (last response written), go to DONE on the next edge.
  - DONE: out_valid=1. A_out/V_out hold stable. On out_ready, out_valid drops and the state returns to IDLE. in_ready=1 on the following cycle only; there is no same-cycle job turnaround.
- dp_req_valid, once asserted, holds with stable dp_a/dp_b until accepted.
- A_out is the live score buffer. During RUN it shows partial results that consumers must ignore. A is not cleared between jobs; every element is overwritten.
- dp_resp_valid with outstanding=0 is a protocol error: ignored, and no counter changes.
- in_valid in RUN/DONE is ignored (in_ready=0).
- rst mid-RUN or mid-DONE: immediate return to reset values; in-flight engine results are discarded.
- Total latency with a 0-wait, L-cycle engine is about TOKEN_NUM²+L+2 cycles per job when MAX_OUTSTANDING≥L.

Optional Feature:
QK_SCHED_PERF_EN.
- Defined: adds output perf_cycles (32 bits). It counts clk cycles spent in RUN for the current job, clears on job capture, holds through DONE/IDLE, resets to 0, and saturates at 0xFFFFFFFF.
- Also adds output perf_stall (32 bits). It counts RUN cycles with dp_req_valid=1 and dp_req_ready=0, with the same clear, hold and saturate rules.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- TOKEN_NUM=2, TOKEN_DIM=2, Q=[[1,0],[0,1]], K=[[2,3],[4,5]] (fp16 0x3C00 etc.), engine latency 1, always ready -> A_out=[[2,4],[3,5]] = 0x4000,0x4400,0x4200,0x4500 and out_valid exactly once.
- Engine latency 6, MAX_OUTSTANDING=4 -> outstanding never exceeds 4; dp_req_valid drops at 4 outstanding; A is correct.
- dp_req_ready toggles 0/1 each cycle -> dp_a/dp_b stable while stalled; 4 requests issued in order (0,0),(0,1),(1,0),(1,1).
- out_ready held 0 for 10 cycles in DONE -> out_valid and A_out stable, in_ready=0; after out_ready, in_ready=1 the next cycle.
- rst asserted after 2 responses in RUN -> next cycle out_valid=0, in_ready=1, A_out=0; a late dp_resp_valid is ignored.
- With QK_SCHED_PERF_EN, the alternating-ready case gives perf_stall=number of stalled cycles (bench-counted) and perf_cycles=total RUN cycles.
